// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle for the execute stage.
// The master side issues operations; the slave side (the ALU) returns registered results.
interface alu_exec_unit_if;
    logic        in_valid;
    logic [4:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [5:0]  ctrl;
    logic [31:0] r;
    logic [31:0] r2;
    logic        z;

    modport master (
        output in_valid, alu_op, funct, shamt, a, b,
        input  out_valid, ctrl, r, r2, z
    );

    modport slave (
        input  in_valid, alu_op, funct, shamt, a, b,
        output out_valid, ctrl, r, r2, z
    );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS-style execute stage: ALU-control decode fused with a 32-bit ALU, one cycle of latency.
// Define ALU_MULT_EN to build MULT/MULTU; otherwise funct 18/19 decode to NOP.
module alu_exec_unit #(
    parameter logic [31:0] THRESH_HI = 32'd255
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);

    typedef enum logic [5:0] {
        CT_NOP    = 6'h00,
        CT_ADD    = 6'h01,
        CT_SUB    = 6'h02,
        CT_AND    = 6'h03,
        CT_OR     = 6'h04,
        CT_XOR    = 6'h05,
        CT_NOR    = 6'h06,
        CT_SLT    = 6'h07,
        CT_SLTU   = 6'h08,
        CT_SLL    = 6'h09,
        CT_SRL    = 6'h0A,
        CT_SRA    = 6'h0B,
        CT_SLLV   = 6'h0C,
        CT_SRLV   = 6'h0D,
        CT_SRAV   = 6'h0E,
        CT_MULT   = 6'h0F,
        CT_MULTU  = 6'h10,
        CT_LUI    = 6'h11,
        CT_THRESH = 6'h12
    } alu_ctrl_t;

    alu_ctrl_t   ctrl_next;
    logic [31:0] r_next;
    logic [31:0] r2_next;

    always_comb begin
        ctrl_next = CT_NOP;
        case (bus.alu_op)
            5'h00: ctrl_next = CT_ADD;
            5'h01: ctrl_next = CT_SUB;
            5'h02: begin
                case (bus.funct)
                    6'h20, 6'h21: ctrl_next = CT_ADD;
                    6'h22, 6'h23: ctrl_next = CT_SUB;
                    6'h24:        ctrl_next = CT_AND;
                    6'h25:        ctrl_next = CT_OR;
                    6'h26:        ctrl_next = CT_XOR;
                    6'h27:        ctrl_next = CT_NOR;
                    6'h2A:        ctrl_next = CT_SLT;
                    6'h2B:        ctrl_next = CT_SLTU;
                    6'h00:        ctrl_next = CT_SLL;
                    6'h02:        ctrl_next = CT_SRL;
                    6'h03:        ctrl_next = CT_SRA;
                    6'h04:        ctrl_next = CT_SLLV;
                    6'h06:        ctrl_next = CT_SRLV;
                    6'h07:        ctrl_next = CT_SRAV;
`ifdef ALU_MULT_EN
                    6'h18:        ctrl_next = CT_MULT;
                    6'h19:        ctrl_next = CT_MULTU;
`endif
                    6'h32:        ctrl_next = CT_THRESH;
                    default:      ctrl_next = CT_NOP;
                endcase
            end
            5'h03: ctrl_next = CT_AND;
            5'h04: ctrl_next = CT_OR;
            5'h05: ctrl_next = CT_XOR;
            5'h06: ctrl_next = CT_SLT;
            5'h07: ctrl_next = CT_SLTU;
            5'h08: ctrl_next = CT_LUI;
            default: ctrl_next = CT_NOP;
        endcase
    end

`ifdef ALU_MULT_EN
    // Operands are extended to 64 bits so the low 64 bits of the product are exact for both signednesses.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    assign prod_u = {32'b0, bus.a} * {32'b0, bus.b};
`endif

    always_comb begin
        r_next  = 32'd0;
        r2_next = 32'd0;
        case (ctrl_next)
            CT_ADD:    r_next = bus.a + bus.b;
            CT_SUB:    r_next = bus.a - bus.b;
            CT_AND:    r_next = bus.a & bus.b;
            CT_OR:     r_next = bus.a | bus.b;
            CT_XOR:    r_next = bus.a ^ bus.b;
            CT_NOR:    r_next = ~(bus.a | bus.b);
            CT_SLT:    r_next = {31'b0, $signed(bus.a) < $signed(bus.b)};
            CT_SLTU:   r_next = {31'b0, bus.a < bus.b};
            CT_SLL:    r_next = bus.b << bus.shamt;
            CT_SRL:    r_next = bus.b >> bus.shamt;
            CT_SRA:    r_next = $signed(bus.b) >>> bus.shamt;
            CT_SLLV:   r_next = bus.b << bus.a[4:0];
            CT_SRLV:   r_next = bus.b >> bus.a[4:0];
            CT_SRAV:   r_next = $signed(bus.b) >>> bus.a[4:0];
            CT_LUI:    r_next = {bus.b[15:0], 16'h0000};
            CT_THRESH: r_next = (bus.a > bus.b) ? THRESH_HI : 32'd0;
`ifdef ALU_MULT_EN
            CT_MULT: begin
                r_next  = prod_s[31:0];
                r2_next = prod_s[63:32];
            end
            CT_MULTU: begin
                r_next  = prod_u[31:0];
                r2_next = prod_u[63:32];
            end
`endif
            default: begin
                r_next  = 32'd0;
                r2_next = 32'd0;
            end
        endcase
    end

    // Results only move on a valid issue; a bubble leaves the last result visible downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.ctrl      <= 6'h00;
            bus.r         <= 32'd0;
            bus.r2        <= 32'd0;
            bus.z         <= 1'b1;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.ctrl <= ctrl_next;
                bus.r    <= r_next;
                bus.r2   <= r2_next;
                bus.z    <= (r_next == 32'd0);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized ops against an arithmetic model.
// Build with or without ALU_MULT_EN; the model follows the same macro.
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_unit_if bus();

    alu_exec_unit dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [31:0] r;
        logic [31:0] r2;
    } exp_t;

    int errors = 0;
    int checks = 0;

    logic        exp_valid;
    logic [5:0]  exp_ctrl;
    logic [31:0] exp_r;
    logic [31:0] exp_r2;
    logic        exp_z;

    logic [5:0] funct_list [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                    6'h18, 6'h19, 6'h32};

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Shifts are expressed as multiply/divide by a power of two, signed ops via int casts.
    function automatic exp_t model(input logic [4:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] pw_sh;
        logic [31:0] pw_a;
        e = '0;
        pw_sh = 32'd1 << sh;
        pw_a  = 32'd1 << a[4:0];
        case (op)
            5'h00: begin e.ctrl = 6'h01; e.r = a + b; end
            5'h01: begin e.ctrl = 6'h02; e.r = a - b; end
            5'h03: begin e.ctrl = 6'h03; e.r = a & b; end
            5'h04: begin e.ctrl = 6'h04; e.r = a | b; end
            5'h05: begin e.ctrl = 6'h05; e.r = a ^ b; end
            5'h06: begin e.ctrl = 6'h07; e.r = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
            5'h07: begin e.ctrl = 6'h08; e.r = (a < b) ? 32'd1 : 32'd0; end
            5'h08: begin e.ctrl = 6'h11; e.r = b * 32'd65536; end
            5'h02: begin
                case (fn)
                    6'h20, 6'h21: begin e.ctrl = 6'h01; e.r = a + b; end
                    6'h22, 6'h23: begin e.ctrl = 6'h02; e.r = a - b; end
                    6'h24: begin e.ctrl = 6'h03; e.r = a & b; end
                    6'h25: begin e.ctrl = 6'h04; e.r = a | b; end
                    6'h26: begin e.ctrl = 6'h05; e.r = a ^ b; end
                    6'h27: begin e.ctrl = 6'h06; e.r = ~(a | b); end
                    6'h2A: begin e.ctrl = 6'h07; e.r = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
                    6'h2B: begin e.ctrl = 6'h08; e.r = (a < b) ? 32'd1 : 32'd0; end
                    6'h00: begin e.ctrl = 6'h09; e.r = b * pw_sh; end
                    6'h02: begin e.ctrl = 6'h0A; e.r = b / pw_sh; end
                    6'h03: begin e.ctrl = 6'h0B; e.r = b[31] ? ~((~b) / pw_sh) : b / pw_sh; end
                    6'h04: begin e.ctrl = 6'h0C; e.r = b * pw_a; end
                    6'h06: begin e.ctrl = 6'h0D; e.r = b / pw_a; end
                    6'h07: begin e.ctrl = 6'h0E; e.r = b[31] ? ~((~b) / pw_a) : b / pw_a; end
                    6'h32: begin e.ctrl = 6'h12; e.r = (a > b) ? 32'd255 : 32'd0; end
`ifdef ALU_MULT_EN
                    6'h18: begin
                        longint sp;
                        logic [63:0] p;
                        sp = longint'(int'(a)) * longint'(int'(b));
                        p = sp;
                        e.ctrl = 6'h0F; e.r = p[31:0]; e.r2 = p[63:32];
                    end
                    6'h19: begin
                        logic [63:0] p;
                        p = {32'd0, a} * {32'd0, b};
                        e.ctrl = 6'h10; e.r = p[31:0]; e.r2 = p[63:32];
                    end
`endif
                    default: e = '0;
                endcase
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic resetModel();
        exp_valid = 1'b0;
        exp_ctrl  = 6'h00;
        exp_r     = 32'd0;
        exp_r2    = 32'd0;
        exp_z     = 1'b1;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_valid));
        checkOutput({tag, ".ctrl"},      64'(bus.ctrl),      64'(exp_ctrl));
        checkOutput({tag, ".r"},         64'(bus.r),         64'(exp_r));
        checkOutput({tag, ".r2"},        64'(bus.r2),        64'(exp_r2));
        checkOutput({tag, ".z"},         64'(bus.z),         64'(exp_z));
    endtask

    task automatic applyStimulus(input string tag, input logic v, input logic [4:0] op,
                                 input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bus.in_valid = v;
        bus.alu_op   = op;
        bus.funct    = fn;
        bus.shamt    = sh;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) begin
            e = model(op, fn, sh, a, b);
            exp_ctrl = e.ctrl;
            exp_r    = e.r;
            exp_r2   = e.r2;
            exp_z    = (e.r == 32'd0);
        end
        checkAll(tag);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_op = '0;
        bus.funct = '0;
        bus.shamt = '0;
        bus.a = '0;
        bus.b = '0;
        resetModel();
        #12;
        checkAll("reset");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("thresh_pass", 1'b1, 5'h02, 6'h32, 5'd0, 32'd150, 32'd128);
        checkOutput("thresh_pass_r", 64'(bus.r), 64'd255);
        checkOutput("thresh_pass_ctrl", 64'(bus.ctrl), 64'h12);
        checkOutput("thresh_pass_z", 64'(bus.z), 64'd0);

        // Reset between edges must clear outputs without waiting for a clock.
        #2 rst = 1'b1;
        #1;
        resetModel();
        checkAll("async_reset");
        #1 rst = 1'b0;

        applyStimulus("thresh_below", 1'b1, 5'h02, 6'h32, 5'd0, 32'd100, 32'd128);
        checkOutput("thresh_below_r", 64'(bus.r), 64'd0);
        applyStimulus("thresh_equal", 1'b1, 5'h02, 6'h32, 5'd0, 32'd128, 32'd128);
        checkOutput("thresh_equal_z", 64'(bus.z), 64'd1);
        applyStimulus("sub_neg", 1'b1, 5'h02, 6'h22, 5'd0, 32'd5, 32'd7);
        checkOutput("sub_neg_r", 64'(bus.r), 64'hFFFF_FFFE);
        applyStimulus("hold", 1'b0, 5'h00, 6'h00, 5'd0, 32'd1, 32'd1);
        checkOutput("hold_r", 64'(bus.r), 64'hFFFF_FFFE);
        applyStimulus("slt", 1'b1, 5'h02, 6'h2A, 5'd0, 32'd5, 32'd7);
        checkOutput("slt_r", 64'(bus.r), 64'd1);
        applyStimulus("sra", 1'b1, 5'h02, 6'h03, 5'd4, 32'd0, 32'h8000_0000);
        checkOutput("sra_r", 64'(bus.r), 64'hF800_0000);
        applyStimulus("mult", 1'b1, 5'h02, 6'h18, 5'd0, 32'hFFFF_FFFE, 32'd3);
`ifdef ALU_MULT_EN
        checkOutput("mult_r", 64'(bus.r), 64'hFFFF_FFFA);
        checkOutput("mult_r2", 64'(bus.r2), 64'hFFFF_FFFF);
`else
        checkOutput("mult_r", 64'(bus.r), 64'd0);
        checkOutput("mult_r2", 64'(bus.r2), 64'd0);
`endif
        applyStimulus("lui", 1'b1, 5'h08, 6'h00, 5'd0, 32'd0, 32'h0000_1234);
        checkOutput("lui_r", 64'(bus.r), 64'h1234_0000);
        applyStimulus("nop_op", 1'b1, 5'h1F, 6'h20, 5'd0, 32'd9, 32'd9);

        for (int i = 0; i < 400; i++) begin
            logic [4:0]  op;
            logic [5:0]  fn;
            logic [31:0] a;
            logic [31:0] b;
            op = ($urandom_range(0, 9) == 9) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
            if ($urandom_range(0, 4) == 0) op = 5'h02;
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : funct_list[$urandom_range(0, 18)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 300));
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 300));
            if ($urandom_range(0, 7) == 0) b = a;
            applyStimulus("random", ($urandom_range(0, 4) != 0), op, fn, 5'($urandom), a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
